// File: rtl/gan.sv
// gan -- pipelined fixed-point inference engine for a small GAN-style MLP chain.
//
// Discriminator path (layers 1-4, widths 4->4->2->1->1) feeds its scalar output
// into the generator path (layers 5-8, widths 1->2->4->4). Each layer owns one
// register stage, so a vector sampled at edge n appears on out1..out4 after
// edge n+7, and a new vector can enter every cycle.
//
// Arithmetic: signed integer products and sums at 2*WIDTH bits, then reduced to
// the destination width. ReLU follows layers 1-7; layer 8 is linear.
//
// Build option:
//   GAN_SAT_EN  defined   -> layer results saturate to the destination range
//               undefined -> layer results wrap (two's complement truncation)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, x_1..x_4  input vector and its valid flag
//   wL_ij, bL_j         quasi-static weights (input i -> neuron j) and biases
//   out_valid, out1..4  layer-8 results and their valid flag
module gan #(
  parameter int WIDTH    = 32,
  parameter int WIDTH_L8 = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic signed [WIDTH-1:0]    x_1, x_2, x_3, x_4,
  input  logic signed [WIDTH-1:0]    w1_11, w1_12, w1_13, w1_14,
  input  logic signed [WIDTH-1:0]    w1_21, w1_22, w1_23, w1_24,
  input  logic signed [WIDTH-1:0]    w1_31, w1_32, w1_33, w1_34,
  input  logic signed [WIDTH-1:0]    w1_41, w1_42, w1_43, w1_44,
  input  logic signed [WIDTH-1:0]    b1_1, b1_2, b1_3, b1_4,
  input  logic signed [WIDTH-1:0]    w2_11, w2_12, w2_21, w2_22,
  input  logic signed [WIDTH-1:0]    w2_31, w2_32, w2_41, w2_42,
  input  logic signed [WIDTH-1:0]    b2_1, b2_2,
  input  logic signed [WIDTH-1:0]    w3_11, w3_21, b3_1,
  input  logic signed [WIDTH-1:0]    w4_11, b4_1,
  input  logic signed [WIDTH-1:0]    w5_11, b5_1,
  input  logic signed [WIDTH-1:0]    w6_11, w6_12, b6_1, b6_2,
  input  logic signed [WIDTH-1:0]    w7_11, w7_12, w7_13, w7_14,
  input  logic signed [WIDTH-1:0]    w7_21, w7_22, w7_23, w7_24,
  input  logic signed [WIDTH-1:0]    b7_1, b7_2, b7_3, b7_4,
  input  logic signed [WIDTH-1:0]    w8_11, w8_12, w8_13, w8_14,
  input  logic signed [WIDTH-1:0]    w8_21, w8_22, w8_23, w8_24,
  input  logic signed [WIDTH-1:0]    w8_31, w8_32, w8_33, w8_34,
  input  logic signed [WIDTH-1:0]    w8_41, w8_42, w8_43, w8_44,
  input  logic signed [WIDTH-1:0]    b8_1, b8_2, b8_3, b8_4,
  output logic                       out_valid,
  output logic signed [WIDTH_L8-1:0] out1, out2, out3, out4
);

  localparam int SW = 2 * WIDTH;
  // Wide enough to hold either the full sum or the layer-8 width plus a sign guard.
  localparam int XW = ((SW > WIDTH_L8) ? SW : WIDTH_L8) + 1;

`ifdef GAN_SAT_EN
  localparam logic signed [SW-1:0] W_MAX  = (SW'(1) <<< (WIDTH - 1)) - SW'(1);
  localparam logic signed [SW-1:0] W_MIN  = -(SW'(1) <<< (WIDTH - 1));
  localparam logic signed [XW-1:0] L8_MAX = (XW'(1) <<< (WIDTH_L8 - 1)) - XW'(1);
  localparam logic signed [XW-1:0] L8_MIN = -(XW'(1) <<< (WIDTH_L8 - 1));
`endif

  // Full-precision signed product of one activation and one weight.
  function automatic logic signed [SW-1:0] mac(input logic signed [WIDTH-1:0] a,
                                               input logic signed [WIDTH-1:0] w);
    return SW'(a) * SW'(w);
  endfunction

  // Reduce a full-precision sum to an activation-width value.
  function automatic logic signed [WIDTH-1:0] fitW(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] c;
    c = v;
`ifdef GAN_SAT_EN
    if (v > W_MAX)      c = W_MAX;
    else if (v < W_MIN) c = W_MIN;
`endif
    return WIDTH'(c);
  endfunction

  // Reduce a full-precision sum to the layer-8 output width. In wrap mode the
  // value is first wrapped to WIDTH and then sign-extended or truncated.
  function automatic logic signed [WIDTH_L8-1:0] fitL8(input logic signed [SW-1:0] v);
    logic signed [XW-1:0] e;
`ifdef GAN_SAT_EN
    e = XW'(v);
    if (e > L8_MAX)      e = L8_MAX;
    else if (e < L8_MIN) e = L8_MIN;
`else
    e = XW'(fitW(v));
`endif
    return WIDTH_L8'(e);
  endfunction

  function automatic logic signed [WIDTH-1:0] relu(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? '0 : v;
  endfunction

  // Port bundles regrouped as [input][neuron] arrays so the layers can loop.
  logic signed [WIDTH-1:0] xa [4];
  logic signed [WIDTH-1:0] w1 [4][4];
  logic signed [WIDTH-1:0] b1 [4];
  logic signed [WIDTH-1:0] w2 [4][2];
  logic signed [WIDTH-1:0] b2 [2];
  logic signed [WIDTH-1:0] w6 [2];
  logic signed [WIDTH-1:0] b6 [2];
  logic signed [WIDTH-1:0] w7 [2][4];
  logic signed [WIDTH-1:0] b7 [4];
  logic signed [WIDTH-1:0] w8 [4][4];
  logic signed [WIDTH-1:0] b8 [4];

  assign xa = '{x_1, x_2, x_3, x_4};
  assign w1 = '{'{w1_11, w1_12, w1_13, w1_14}, '{w1_21, w1_22, w1_23, w1_24},
                '{w1_31, w1_32, w1_33, w1_34}, '{w1_41, w1_42, w1_43, w1_44}};
  assign b1 = '{b1_1, b1_2, b1_3, b1_4};
  assign w2 = '{'{w2_11, w2_12}, '{w2_21, w2_22}, '{w2_31, w2_32}, '{w2_41, w2_42}};
  assign b2 = '{b2_1, b2_2};
  assign w6 = '{w6_11, w6_12};
  assign b6 = '{b6_1, b6_2};
  assign w7 = '{'{w7_11, w7_12, w7_13, w7_14}, '{w7_21, w7_22, w7_23, w7_24}};
  assign b7 = '{b7_1, b7_2, b7_3, b7_4};
  assign w8 = '{'{w8_11, w8_12, w8_13, w8_14}, '{w8_21, w8_22, w8_23, w8_24},
                '{w8_31, w8_32, w8_33, w8_34}, '{w8_41, w8_42, w8_43, w8_44}};
  assign b8 = '{b8_1, b8_2, b8_3, b8_4};

  logic signed [WIDTH-1:0]    s1_q [4], s1_d [4];
  logic signed [WIDTH-1:0]    s2_q [2], s2_d [2];
  logic signed [WIDTH-1:0]    s3_q, s3_d, s4_q, s4_d, s5_q, s5_d;
  logic signed [WIDTH-1:0]    s6_q [2], s6_d [2];
  logic signed [WIDTH-1:0]    s7_q [4], s7_d [4];
  logic signed [WIDTH_L8-1:0] s8_q [4], s8_d [4];
  logic [7:0]                 valid_q, valid_d;
  logic signed [SW-1:0]       acc;

  // Every layer evaluates combinationally from the previous stage register;
  // layer 1 reads the raw inputs, so x is registered only once, in stage 1.
  always_comb begin
    acc = '0;
    for (int j = 0; j < 4; j++) begin
      acc = SW'(b1[j]);
      for (int i = 0; i < 4; i++) acc = acc + mac(xa[i], w1[i][j]);
      s1_d[j] = relu(fitW(acc));
    end
    for (int j = 0; j < 2; j++) begin
      acc = SW'(b2[j]);
      for (int i = 0; i < 4; i++) acc = acc + mac(s1_q[i], w2[i][j]);
      s2_d[j] = relu(fitW(acc));
    end
    acc  = SW'(b3_1) + mac(s2_q[0], w3_11) + mac(s2_q[1], w3_21);
    s3_d = relu(fitW(acc));
    acc  = SW'(b4_1) + mac(s3_q, w4_11);
    s4_d = relu(fitW(acc));
    acc  = SW'(b5_1) + mac(s4_q, w5_11);
    s5_d = relu(fitW(acc));
    for (int j = 0; j < 2; j++) begin
      acc     = SW'(b6[j]) + mac(s5_q, w6[j]);
      s6_d[j] = relu(fitW(acc));
    end
    for (int j = 0; j < 4; j++) begin
      acc     = SW'(b7[j]) + mac(s6_q[0], w7[0][j]) + mac(s6_q[1], w7[1][j]);
      s7_d[j] = relu(fitW(acc));
    end
    for (int j = 0; j < 4; j++) begin
      acc = SW'(b8[j]);
      for (int i = 0; i < 4; i++) acc = acc + mac(s7_q[i], w8[i][j]);
      s8_d[j] = fitL8(acc);
    end
    valid_d = {valid_q[6:0], in_valid};
  end

  // Data stages advance every cycle regardless of valid; only the valid chain
  // marks which slots carry real vectors. Reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '{default: '0};
      s2_q    <= '{default: '0};
      s3_q    <= '0;
      s4_q    <= '0;
      s5_q    <= '0;
      s6_q    <= '{default: '0};
      s7_q    <= '{default: '0};
      s8_q    <= '{default: '0};
      valid_q <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      s4_q    <= s4_d;
      s5_q    <= s5_d;
      s6_q    <= s6_d;
      s7_q    <= s7_d;
      s8_q    <= s8_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q[7];
  assign out1      = s8_q[0];
  assign out2      = s8_q[1];
  assign out3      = s8_q[2];
  assign out4      = s8_q[3];

endmodule

// File: tb/tb_gan.sv
// tb_gan -- self-checking bench for gan (default WIDTH = WIDTH_L8 = 32).
// A behavioural model computes each layer with 64-bit integer arithmetic over
// weight/bias tables and predicts out1..out4; also honours GAN_SAT_EN.
module tb_gan;

  logic        clk;
  logic        rst_n;
  logic        inValid;
  int          xIn [4];
  int          W [8][4][4];
  int          B [8][4];
  logic        out_valid;
  logic signed [31:0] out1, out2, out3, out4;
  logic signed [31:0] outs [4];
  int          nChecks;
  int          nFail;

  localparam int NIN  [8] = '{4, 4, 2, 1, 1, 1, 2, 4};
  localparam int NOUT [8] = '{4, 2, 1, 1, 1, 2, 4, 4};

  assign outs = '{out1, out2, out3, out4};

  gan dut (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid),
    .x_1(xIn[0]), .x_2(xIn[1]), .x_3(xIn[2]), .x_4(xIn[3]),
    .w1_11(W[0][0][0]), .w1_12(W[0][0][1]), .w1_13(W[0][0][2]), .w1_14(W[0][0][3]),
    .w1_21(W[0][1][0]), .w1_22(W[0][1][1]), .w1_23(W[0][1][2]), .w1_24(W[0][1][3]),
    .w1_31(W[0][2][0]), .w1_32(W[0][2][1]), .w1_33(W[0][2][2]), .w1_34(W[0][2][3]),
    .w1_41(W[0][3][0]), .w1_42(W[0][3][1]), .w1_43(W[0][3][2]), .w1_44(W[0][3][3]),
    .b1_1(B[0][0]), .b1_2(B[0][1]), .b1_3(B[0][2]), .b1_4(B[0][3]),
    .w2_11(W[1][0][0]), .w2_12(W[1][0][1]), .w2_21(W[1][1][0]), .w2_22(W[1][1][1]),
    .w2_31(W[1][2][0]), .w2_32(W[1][2][1]), .w2_41(W[1][3][0]), .w2_42(W[1][3][1]),
    .b2_1(B[1][0]), .b2_2(B[1][1]),
    .w3_11(W[2][0][0]), .w3_21(W[2][1][0]), .b3_1(B[2][0]),
    .w4_11(W[3][0][0]), .b4_1(B[3][0]),
    .w5_11(W[4][0][0]), .b5_1(B[4][0]),
    .w6_11(W[5][0][0]), .w6_12(W[5][0][1]), .b6_1(B[5][0]), .b6_2(B[5][1]),
    .w7_11(W[6][0][0]), .w7_12(W[6][0][1]), .w7_13(W[6][0][2]), .w7_14(W[6][0][3]),
    .w7_21(W[6][1][0]), .w7_22(W[6][1][1]), .w7_23(W[6][1][2]), .w7_24(W[6][1][3]),
    .b7_1(B[6][0]), .b7_2(B[6][1]), .b7_3(B[6][2]), .b7_4(B[6][3]),
    .w8_11(W[7][0][0]), .w8_12(W[7][0][1]), .w8_13(W[7][0][2]), .w8_14(W[7][0][3]),
    .w8_21(W[7][1][0]), .w8_22(W[7][1][1]), .w8_23(W[7][1][2]), .w8_24(W[7][1][3]),
    .w8_31(W[7][2][0]), .w8_32(W[7][2][1]), .w8_33(W[7][2][2]), .w8_34(W[7][2][3]),
    .w8_41(W[7][3][0]), .w8_42(W[7][3][1]), .w8_43(W[7][3][2]), .w8_44(W[7][3][3]),
    .b8_1(B[7][0]), .b8_2(B[7][1]), .b8_3(B[7][2]), .b8_4(B[7][3]),
    .out_valid(out_valid), .out1(out1), .out2(out2), .out3(out3), .out4(out4)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reduce a 64-bit sum to a 32-bit layer result (wrap, or clamp when saturating).
  function automatic int fit(input longint s);
`ifdef GAN_SAT_EN
    if (s > 64'sd2147483647)  return 32'sh7fffffff;
    if (s < -64'sd2147483648) return 32'sh80000000;
`endif
    return int'(s);
  endfunction

  // Whole-network reference: y = sum(w*a) + b per neuron, ReLU on layers 1-7.
  function automatic void model(input int xv [4], output int y [4]);
    int     a [4];
    int     t [4];
    longint s;
    a = xv;
    for (int l = 0; l < 8; l++) begin
      for (int j = 0; j < 4; j++) t[j] = 0;
      for (int j = 0; j < NOUT[l]; j++) begin
        s = longint'(B[l][j]);
        for (int i = 0; i < NIN[l]; i++) s += longint'(W[l][i][j]) * longint'(a[i]);
        t[j] = fit(s);
        if (l < 7 && t[j] < 0) t[j] = 0;
      end
      a = t;
    end
    y = a;
  endfunction

  // Load the reference weight set, clearing unused table slots.
  task automatic setRefWeights();
    for (int l = 0; l < 8; l++)
      for (int i = 0; i < 4; i++) begin
        B[l][i] = 0;
        for (int j = 0; j < 4; j++) W[l][i][j] = 0;
      end
    W[0] = '{'{6, 21, 3, 18}, '{-3, 16, -3, 12}, '{5, -6, -15, -4}, '{-16, -9, -17, -8}};
    B[0] = '{1, 0, 2, -1};
    W[1] = '{'{4, -14, 0, 0}, '{14, 14, 0, 0}, '{8, 9, 0, 0}, '{15, 15, 0, 0}};
    B[1] = '{1, 4, 0, 0};
    W[2][0][0] = 14; W[2][1][0] = 6; B[2][0] = 5;
    W[3][0][0] = 7;  B[3][0] = 10;
    W[4][0][0] = 1;  B[4][0] = -4;
    W[5][0][0] = -8; W[5][0][1] = 14; B[5] = '{20, 0, 0, 0};
    W[6][0] = '{4, 14, 8, 15};
    W[6][1] = '{-14, 14, 9, 15};
    B[6] = '{5, 3, 1, 2};
    W[7] = '{'{11, -7, 10, -7}, '{9, -6, 11, -7}, '{10, -15, -5, 7}, '{1, 17, 4, 12}};
    B[7] = '{-10, 10, 10, -10};
  endtask

  // Present one vector for one cycle, then count negedges until out_valid (bounded).
  task automatic sendOne(input int xv [4], output int cyc);
    @(negedge clk);
    xIn = xv;
    inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Reset held with random inputs toggling: outputs must remain cleared.
  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) xIn[i] = int'($urandom);
      inValid = 1'($urandom_range(1));
      #1;
      nChecks++;
      if (out_valid !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL reset_valid cycle %0d: got %b expected 0", c, out_valid);
      end
      for (int k = 0; k < 4; k++) begin
        nChecks++;
        if (outs[k] !== 32'sd0) begin
          nFail++;
          $display("[TB] FAIL reset_out%0d cycle %0d: got %0d expected 0", k + 1, c, outs[k]);
        end
      end
    end
    @(negedge clk);
    inValid = 1'b0;
    rst_n = 1'b1;
  endtask

  // Known reference vector with literal expected results and 8-cycle latency.
  task automatic test_reference();
    int xv [4];
    int req [4];
    int cyc;
    setRefWeights();
    xv  = '{0, 1, 1, 0};
    req = '{110017475, 17145587, 80489000, 69058570};
    sendOne(xv, cyc);
    nChecks++;
    if (cyc != 8) begin
      nFail++;
      $display("[TB] FAIL ref_latency: got %0d cycles expected 8", cyc);
    end
    for (int k = 0; k < 4; k++) begin
      nChecks++;
      if (outs[k] !== req[k]) begin
        nFail++;
        $display("[TB] FAIL ref_out%0d: got %0d expected %0d", k + 1, outs[k], req[k]);
      end
    end
  endtask

  // Zero input: layer-1 neuron 4 goes negative and must clamp to zero.
  task automatic test_relu();
    int xv [4];
    int e [4];
    int cyc;
    setRefWeights();
    xv = '{0, 0, 0, 0};
    model(xv, e);
    sendOne(xv, cyc);
    nChecks++;
    if (cyc != 8) begin
      nFail++;
      $display("[TB] FAIL relu_latency: got %0d cycles expected 8", cyc);
    end
    for (int k = 0; k < 4; k++) begin
      nChecks++;
      if (outs[k] !== e[k]) begin
        nFail++;
        $display("[TB] FAIL relu_out%0d: got %0d expected %0d", k + 1, outs[k], e[k]);
      end
    end
  endtask

  // Three random vectors back to back must emerge on three consecutive cycles.
  task automatic test_back_to_back();
    int xs [3][4];
    int e  [3][4];
    int cyc;
    setRefWeights();
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 4; i++) xs[v][i] = int'($urandom_range(200)) - 100;
      model(xs[v], e[v]);
    end
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      xIn = xs[v];
      inValid = 1'b1;
    end
    @(negedge clk);
    inValid = 1'b0;
    cyc = 3;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    nChecks++;
    if (cyc != 8) begin
      nFail++;
      $display("[TB] FAIL stream_latency: got %0d cycles expected 8", cyc);
    end
    for (int v = 0; v < 3; v++) begin
      if (v > 0) @(negedge clk);
      nChecks++;
      if (out_valid !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL stream_valid%0d: got %b expected 1", v, out_valid);
      end
      for (int k = 0; k < 4; k++) begin
        nChecks++;
        if (outs[k] !== e[v][k]) begin
          nFail++;
          $display("[TB] FAIL stream_v%0d_out%0d: got %0d expected %0d", v, k + 1, outs[k], e[v][k]);
        end
      end
    end
    @(negedge clk);
    nChecks++;
    if (out_valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL stream_tail_valid: got %b expected 0", out_valid);
    end
  endtask

  // Reset four cycles after launch: vector is dropped, outputs clear at once.
  task automatic test_reset_midflight();
    int xv [4];
    int pulses;
    int cyc;
    setRefWeights();
    xv = '{0, 1, 1, 0};
    @(negedge clk);
    xIn = xv;
    inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    nChecks++;
    if (out_valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL midrst_valid: got %b expected 0", out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      nChecks++;
      if (outs[k] !== 32'sd0) begin
        nFail++;
        $display("[TB] FAIL midrst_out%0d: got %0d expected 0", k + 1, outs[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) pulses++;
    end
    nChecks++;
    if (pulses != 0) begin
      nFail++;
      $display("[TB] FAIL midrst_pulses: got %0d expected 0", pulses);
    end
    sendOne(xv, cyc);
    nChecks++;
    if (cyc != 8) begin
      nFail++;
      $display("[TB] FAIL midrst_relaunch_latency: got %0d cycles expected 8", cyc);
    end
  endtask

  // Large layer-4 gain forces the 32-bit range to overflow downstream.
  task automatic test_overflow();
    int xv [4];
    int e [4];
    int cyc;
    setRefWeights();
    W[3][0][0] = 1 << 20;
    for (int v = 0; v < 2; v++) begin
      xv = (v == 0) ? '{0, 1, 1, 0} : '{0, 1000, 1000, 0};
      model(xv, e);
      sendOne(xv, cyc);
      nChecks++;
      if (cyc != 8) begin
        nFail++;
        $display("[TB] FAIL ovf%0d_latency: got %0d cycles expected 8", v, cyc);
      end
      for (int k = 0; k < 4; k++) begin
        nChecks++;
        if (outs[k] !== e[k]) begin
          nFail++;
          $display("[TB] FAIL ovf%0d_out%0d: got %0d expected %0d", v, k + 1, outs[k], e[k]);
        end
      end
    end
  endtask

  // Random small weights with full-range inputs.
  task automatic test_random();
    int xv [4];
    int e [4];
    int cyc;
    for (int r = 0; r < 3; r++) begin
      for (int l = 0; l < 8; l++)
        for (int i = 0; i < 4; i++) begin
          B[l][i] = int'($urandom_range(16)) - 8;
          for (int j = 0; j < 4; j++) W[l][i][j] = int'($urandom_range(16)) - 8;
        end
      for (int i = 0; i < 4; i++) xv[i] = int'($urandom);
      model(xv, e);
      sendOne(xv, cyc);
      nChecks++;
      if (cyc != 8) begin
        nFail++;
        $display("[TB] FAIL rand%0d_latency: got %0d cycles expected 8", r, cyc);
      end
      for (int k = 0; k < 4; k++) begin
        nChecks++;
        if (outs[k] !== e[k]) begin
          nFail++;
          $display("[TB] FAIL rand%0d_out%0d: got %0d expected %0d", r, k + 1, outs[k], e[k]);
        end
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    nChecks = 0;
    nFail   = 0;
    rst_n   = 1'b0;
    inValid = 1'b0;
    xIn     = '{0, 0, 0, 0};
    setRefWeights();
    test_reset();
    test_reference();
    test_relu();
    test_back_to_back();
    test_reset_midflight();
    test_overflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  // Backstop against a stalled run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/gan.md
Name: gan

Overview:
- Pipelined fixed-point inference engine for a tiny GAN-style MLP chain.
- Discriminator path: layers 1–4, widths 4→4→2→1→1.
- Generator path: layers 5–8, widths 1→2→4→4. The layer-4 scalar drives layer 5.
- All weights and biases are quasi-static input ports. One register stage per layer.

Parameters:
- WIDTH, 32: signed width of inputs, weights, biases and internal activations.
- WIDTH_L8, 32: signed width of the layer-8 outputs.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  x_1..x_4 valid this cycle
- x_1..x_4  input  WIDTH each  signed input vector
- w1_11..w1_44 (16)  input  WIDTH each  layer-1 weights; w1_ij = input i → neuron j
- b1_1..b1_4  input  WIDTH each  layer-1 biases
- w2_11,w2_12,w2_21,w2_22,w2_31,w2_32,w2_41,w2_42  input  WIDTH each  layer-2 weights (4 in, 2 out)
- b2_1,b2_2  input  WIDTH each  layer-2 biases
- w3_11,w3_21,b3_1  input  WIDTH each  layer 3 (2 in, 1 out)
- w4_11,b4_1  input  WIDTH each  layer 4 (1→1)
- w5_11,b5_1  input  WIDTH each  layer 5 (1→1)
- w6_11,w6_12,b6_1,b6_2  input  WIDTH each  layer 6 (1→2)
- w7_11..w7_14,w7_21..w7_24,b7_1..b7_4  input  WIDTH each  layer 7 (2→4)
- w8_11..w8_44 (16),b8_1..b8_4  input  WIDTH each  layer 8 (4→4)
- out_valid  output  1  out1..out4 valid
- out1..out4  output  WIDTH_L8 each  signed layer-8 results

Behaviour:
- Layer L neuron j: y_j = sum_i(wL_ij * a_i) + bL_j.
  - Inputs a_i are the previous layer's registered outputs; layer 1 uses x_1..x_4 directly.
- Arithmetic:
  - Signed two's complement, integer; no scaling or shift.
  - Products and sums are computed at 2*WIDTH bits.
  - Result is truncated to the low WIDTH bits, wrapping on overflow.
  - Layer 8 is truncated to WIDTH_L8, or sign-extended if WIDTH_L8 > WIDTH.
- Activation:
  - ReLU (negative → 0) after layers 1–7, applied after truncation.
  - Layer 8 is linear; outputs may be negative.
- Pipeline:
  - Stage k register captures layer-k result on each rising clk.
  - Input is registered only through stage 1; there is no separate input register.
  - Latency is exactly 8 cycles: x sampled at edge n gives out1..out4 after edge n+7.
  - Throughput is one vector per cycle.
- Valid handling:
  - in_valid shifts through an 8-deep valid chain; out_valid is its tail.
  - Data registers update every cycle regardless of valid; there is no stall or backpressure.
- Weights and biases must be held stable while a vector is in flight. Changing them mid-flight affects only the stages evaluated after the change.
- Reset: rst_n low asynchronously clears all stage registers, out1..out4 = 0 and out_valid = 0.
  - Vectors in flight are discarded.
  - First valid output is 8 edges after the first in_valid following release.

Optional Feature:
- GAN_SAT_EN defined: every layer result saturates to the signed min/max of its destination width (WIDTH or WIDTH_L8) instead of wrapping; ReLU is applied after saturation.
- GAN_SAT_EN undefined: wrap-around truncation as specified above.

Test Plan:
- Reset: rst_n low with random inputs → out1..out4 = 0, out_valid = 0 immediately and throughout reset.
- Reference vector:
  - Stimulus: x = (0,1,1,0).
  - W1 rows (i=1..4): (6,21,3,18), (-3,16,-3,12), (5,-6,-15,-4), (-16,-9,-17,-8); b1 = (1,0,2,-1).
  - w2_11=4, w2_21=14, w2_31=8, w2_41=15, w2_12=-14, w2_22=14, w2_32=9, w2_42=15; b2 = (1,4).
  - w3 = (14,6), b3 = 5; w4 = 7, b4 = 10; w5 = 1, b5 = -4.
  - w6 = (-8,14), b6 = (20,0).
  - w7_1j = (4,14,8,15), w7_2j = (-14,14,9,15); b7 = (5,3,1,2).
  - W8 rows: (11,-7,10,-7), (9,-6,11,-7), (10,-15,-5,7), (1,17,4,12); b8 = (-10,10,10,-10).
  - Required: 8 cycles later out1 = 110017475, out2 = 17145587, out3 = 80489000, out4 = 69058570, out_valid = 1.
- ReLU clamp: same weights, x = 0 → layer-1 clamps neuron 4 (b1_4 = -1) to 0. Check out1..out4 against a model of the Behaviour rules.
- Streaming: 3 different vectors on consecutive cycles with in_valid = 1 → 3 consecutive out_valid cycles in order, each matching its model result.
- Reset mid-flight: assert rst_n low 4 cycles after in_valid → out_valid never pulses for that vector; outputs stay 0.
- Overflow: w4_11 = 2^20, large upstream value → wrapped result without GAN_SAT_EN; 2^(WIDTH-1)-1 clamp with GAN_SAT_EN.
